mem_bus_arbiter: RTL and testbench

- Shares the single 16-bit address / 8-bit data memory bus between the CPU6 core and a DMA requester (disk/front-panel channel).
- Fixed priority favours DMA; a burst limit stops the CPU starving.
- Sequences each bus cycle with a programmable number of wait states, then returns a one-cycle ready pulse and the captured read data to the winning requester.
- Sits between CPU6's addressBus/dataOutBus/writeEnBus/dataInBus and the memory/peripheral decode.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 98 +++++++++
 tb/tb_mem_bus_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// CPU/DMA requester ports and the shared memory bus port for mem_bus_arbiter.
// master = the arbiter itself; slave = requesters plus memory decode.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic        dma_write;
  logic [15:0] dma_address;
  logic [7:0]  dma_wdata;
  logic        dma_ready;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_write_en;
  logic [7:0]  mem_rdata;
  logic        owner;
  logic        busy;

  modport master (
    input  cpu_req, cpu_write, cpu_address, cpu_wdata,
    output cpu_ready, cpu_rdata,
    input  dma_req, dma_write, dma_address, dma_wdata,
    output dma_ready, dma_rdata,
    output mem_address, mem_wdata, mem_write_en,
    input  mem_rdata,
    output owner, busy
  );

  modport slave (
    output cpu_req, cpu_write, cpu_address, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    output dma_req, dma_write, dma_address, dma_wdata,
    input  dma_ready, dma_rdata,
    input  mem_address, mem_wdata, mem_write_en,
    output mem_rdata,
    input  owner, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA memory bus arbiter: DMA-first with a burst cap; WAIT_STATES+2 cycles request-to-ready.
// Backpressure: requesters hold req until their one-cycle ready; requests are sampled only while idle.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES   = 1,
  parameter int unsigned MAX_DMA_BURST = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [3:0] BURST_MAX = 4'(MAX_DMA_BURST);

  state_t      state;
  state_t      state_next;
  logic        grant_cpu;
  logic        grant_dma;
  logic [3:0]  wait_count;
  logic [3:0]  burst_count;
  logic [15:0] address_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        owner_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  dma_rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    unique case (state)
      IDLE: begin
        // DMA wins unless the CPU has waited through a full burst.
        if (bus.dma_req && (!bus.cpu_req || burst_count < BURST_MAX)) grant_dma = 1'b1;
        else if (bus.cpu_req)                                         grant_cpu = 1'b1;
        if (grant_cpu || grant_dma) state_next = ACCESS;
      end
      ACCESS:  if (wait_count == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_count  <= 4'd0;
      burst_count <= 4'd0;
      address_q   <= 16'd0;
      wdata_q     <= 8'd0;
      write_q     <= 1'b0;
      owner_q     <= 1'b0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
    end else begin
      if (grant_cpu || grant_dma) begin
        address_q  <= grant_dma ? bus.dma_address : bus.cpu_address;
        wdata_q    <= grant_dma ? bus.dma_wdata   : bus.cpu_wdata;
        write_q    <= grant_dma ? bus.dma_write   : bus.cpu_write;
        owner_q    <= grant_dma;
        wait_count <= WAIT_INIT;
      end else if (state == ACCESS && wait_count != 4'd0) begin
        wait_count <= wait_count - 4'd1;
      end

      if (state == ACCESS && wait_count == 4'd0 && !write_q) begin
        if (owner_q) dma_rdata_q <= bus.mem_rdata;
        else         cpu_rdata_q <= bus.mem_rdata;
      end

      // The burst only counts DMA wins taken while the CPU is kept waiting.
      if (state == IDLE) begin
        if (!bus.cpu_req || grant_cpu)
          burst_count <= 4'd0;
        else if (grant_dma && burst_count < BURST_MAX)
          burst_count <= burst_count + 4'd1;
      end
    end
  end

  assign bus.mem_address  = address_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_write_en = (state == ACCESS) && write_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state != IDLE);
  assign bus.cpu_ready    = (state == DONE) && !owner_q;
  assign bus.dma_ready    = (state == DONE) && owner_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.dma_rdata    = dma_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a transaction model.
// Latency: checks sampled on the negedge following each rising edge.
// Backpressure: requests are held until the matching ready, then dropped.
module tb_mem_bus_arbiter;
    localparam int W    = 1;
    localparam int MAXB = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter_if bus0 ();

    mem_bus_arbiter #(.WAIT_STATES(W), .MAX_DMA_BURST(MAXB)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    mem_bus_arbiter #(.WAIT_STATES(0), .MAX_DMA_BURST(MAXB)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] env_mem [16];
    logic [7:0] ref_mem [16];
    logic       pre_en = 1'b0;
    logic [3:0] pre_idx = 4'd0;
    logic [7:0] pre_val = 8'd0;

    always @(posedge clock) begin
        if (bus.mem_write_en)  env_mem[bus.mem_address[3:0]] <= bus.mem_wdata;
        else if (pre_en)       env_mem[pre_idx] <= pre_val;
    end
    assign bus.mem_rdata = env_mem[bus.mem_address[3:0]];

    task automatic preload(input logic [3:0] idx, input logic [7:0] val);
        pre_idx = idx; pre_val = val; pre_en = 1'b1;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++; if ({bus.mem_address, bus.mem_wdata} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 000000", {bus.mem_address, bus.mem_wdata});
        end
        n_cmp++; if ({bus.mem_write_en, bus.cpu_ready, bus.dma_ready, bus.owner, bus.busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.mem_write_en, bus.cpu_ready, bus.dma_ready, bus.owner, bus.busy});
        end
        n_cmp++; if ({bus.cpu_rdata, bus.dma_rdata} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0000", {bus.cpu_rdata, bus.dma_rdata});
        end
        n_cmp++; if (bus0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy0: got %b expected 0", bus0.busy);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if (bus.busy !== 1'b0 || bus.cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0/0", bus.busy, bus.cpu_ready);
        end
    endtask

    task automatic test_cpu_read();
        int wen_seen = 0;
        preload(4'h4, 8'hA5);
        bus.cpu_address = 16'h1234; bus.cpu_write = 1'b0; bus.cpu_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.cpu_ready !== (k == 3)) begin
                n_fail++;
                $display("FAIL cpu_read_ready c%0d: got %b expected %b", k, bus.cpu_ready, (k == 3));
            end
            n_cmp++; if (bus.busy !== (k <= 3)) begin
                n_fail++;
                $display("FAIL cpu_read_busy c%0d: got %b expected %b", k, bus.busy, (k <= 3));
            end
            if (k <= 2) begin
                n_cmp++; if (bus.mem_address !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL cpu_read_addr c%0d: got %h expected 1234", k, bus.mem_address);
                end
            end
            if (bus.mem_write_en === 1'b1) wen_seen++;
            if (k == 3) begin
                n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL cpu_read_data: got %h expected a5", bus.cpu_rdata);
                end
                bus.cpu_req = 1'b0;
            end
        end
        n_cmp++; if (wen_seen != 0) begin
            n_fail++;
            $display("FAIL cpu_read_wen: got %0d write cycles expected 0", wen_seen);
        end
    endtask

    task automatic test_dma_write();
        int wen_cycles = 0;
        int readies = 0;
        bus.dma_address = 16'h8000; bus.dma_wdata = 8'h3C; bus.dma_write = 1'b1; bus.dma_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (bus.mem_write_en === 1'b1) begin
                wen_cycles++;
                n_cmp++; if (bus.mem_wdata !== 8'h3C || bus.mem_address !== 16'h8000) begin
                    n_fail++;
                    $display("FAIL dma_write_bus c%0d: got %h/%h expected 8000/3c", k, bus.mem_address, bus.mem_wdata);
                end
            end
            if (bus.dma_ready === 1'b1) begin
                readies++;
                bus.dma_req = 1'b0;
            end
            if (k == 1) begin
                n_cmp++; if (bus.owner !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dma_write_owner: got %b expected 1", bus.owner);
                end
            end
        end
        n_cmp++; if (wen_cycles != 2) begin
            n_fail++;
            $display("FAIL dma_write_wen: got %0d cycles expected 2", wen_cycles);
        end
        n_cmp++; if (readies != 1) begin
            n_fail++;
            $display("FAIL dma_write_ready: got %0d pulses expected 1", readies);
        end
        n_cmp++; if (bus.dma_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL dma_write_rdata: got %h expected 00", bus.dma_rdata);
        end
    endtask

    task automatic test_burst();
        int   got [$];
        logic prev_busy = 1'b0;
        int   budget = 0;
        bus.cpu_address = 16'h0001; bus.cpu_write = 1'b0;
        bus.dma_address = 16'h0002; bus.dma_write = 1'b0;
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        while (got.size() < 10 && budget < 80) begin
            @(negedge clock);
            budget++;
            if (bus.busy === 1'b1 && !prev_busy) got.push_back(int'(bus.owner));
            prev_busy = bus.busy;
        end
        n_cmp++; if (got.size() != 10) begin
            n_fail++;
            $display("FAIL burst_timeout: got %0d grants expected 10", got.size());
        end
        foreach (got[g]) begin
            n_cmp++; if (got[g] != ((g % 5 == 4) ? 0 : 1)) begin
                n_fail++;
                $display("FAIL burst_order g%0d: got owner %0d expected %0d", g, got[g], (g % 5 == 4) ? 0 : 1);
            end
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        repeat (6) @(negedge clock);
        n_cmp++; if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_drain: got busy %b expected 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        bus0.cpu_address = 16'h0042; bus0.cpu_write = 1'b0; bus0.cpu_req = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clock);
            n_cmp++; if (bus0.cpu_ready !== (k % 3 == 2 && k <= 11)) begin
                n_fail++;
                $display("FAIL b2b_ready c%0d: got %b expected %b", k, bus0.cpu_ready, (k % 3 == 2 && k <= 11));
            end
            n_cmp++; if (bus0.busy !== (k % 3 != 0 && k <= 11)) begin
                n_fail++;
                $display("FAIL b2b_busy c%0d: got %b expected %b", k, bus0.busy, (k % 3 != 0 && k <= 11));
            end
            if (bus0.cpu_ready === 1'b1) begin
                n_cmp++; if (bus0.cpu_rdata !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL b2b_rdata c%0d: got %h expected 5a", k, bus0.cpu_rdata);
                end
            end
            if (k == 11) bus0.cpu_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_write();
        bus.cpu_address = 16'h0007; bus.cpu_wdata = 8'h99; bus.cpu_write = 1'b1; bus.cpu_req = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.mem_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wen1: got %b expected 1", bus.mem_write_en);
        end
        @(negedge clock);
        n_cmp++; if (bus.mem_write_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wen2: got %b expected 1", bus.mem_write_en);
        end
        reset = 1'b1; bus.cpu_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_write_en !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got wen=%b busy=%b expected 0/0", bus.mem_write_en, bus.busy);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.cpu_ready !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet c%0d: got ready=%b busy=%b expected 0/0", k, bus.cpu_ready, bus.busy);
            end
        end
        bus.cpu_write = 1'b0; bus.cpu_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.cpu_ready !== (k == 3)) begin
                n_fail++;
                $display("FAIL rst_next_ready c%0d: got %b expected %b", k, bus.cpu_ready, (k == 3));
            end
            if (k == 3) begin
                n_cmp++; if (bus.cpu_rdata !== 8'h99) begin
                    n_fail++;
                    $display("FAIL rst_next_rdata: got %h expected 99", bus.cpu_rdata);
                end
                bus.cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_drop_mid();
        bus.cpu_address = 16'h0004; bus.cpu_write = 1'b0; bus.cpu_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) bus.cpu_req = 1'b0;
            n_cmp++; if (bus.cpu_ready !== (k == 3)) begin
                n_fail++;
                $display("FAIL drop_ready c%0d: got %b expected %b", k, bus.cpu_ready, (k == 3));
            end
            n_cmp++; if (bus.busy !== (k <= 3)) begin
                n_fail++;
                $display("FAIL drop_busy c%0d: got %b expected %b", k, bus.busy, (k <= 3));
            end
            if (k == 3) begin
                n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL drop_rdata: got %h expected a5", bus.cpu_rdata);
                end
            end
        end
    endtask

    task automatic test_random();
        int          m_left = 0;
        logic        m_owner = 1'b0;
        logic        m_write = 1'b0;
        logic [15:0] m_addr = 16'd0;
        logic [7:0]  m_wdata = 8'd0;
        int          streak = 0;
        logic [7:0]  exp_c_rd = 8'd0;
        logic [7:0]  exp_d_rd = 8'd0;
        logic        c_pend = 1'b0, d_pend = 1'b0;
        int          c_gap = 0, d_gap = 0;
        logic        win_dma;

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ref_mem[i] = v;
            preload(4'(i), v);
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            n_cmp++; if (bus.busy !== (m_left > 0)) begin
                n_fail++;
                $display("FAIL rnd_busy t%0d: got %b expected %b", cyc, bus.busy, (m_left > 0));
            end
            n_cmp++; if (bus.cpu_ready !== (m_left == 1 && !m_owner)) begin
                n_fail++;
                $display("FAIL rnd_cpu_ready t%0d: got %b expected %b", cyc, bus.cpu_ready, (m_left == 1 && !m_owner));
            end
            n_cmp++; if (bus.dma_ready !== (m_left == 1 && m_owner)) begin
                n_fail++;
                $display("FAIL rnd_dma_ready t%0d: got %b expected %b", cyc, bus.dma_ready, (m_left == 1 && m_owner));
            end
            n_cmp++; if (bus.mem_write_en !== (m_left > 1 && m_write)) begin
                n_fail++;
                $display("FAIL rnd_wen t%0d: got %b expected %b", cyc, bus.mem_write_en, (m_left > 1 && m_write));
            end
            if (m_left > 0) begin
                n_cmp++; if (bus.owner !== m_owner || bus.mem_address !== m_addr) begin
                    n_fail++;
                    $display("FAIL rnd_grant t%0d: got %b/%h expected %b/%h", cyc, bus.owner, bus.mem_address, m_owner, m_addr);
                end
            end
            if (m_left > 1 && m_write) begin
                n_cmp++; if (bus.mem_wdata !== m_wdata) begin
                    n_fail++;
                    $display("FAIL rnd_wdata t%0d: got %h expected %h", cyc, bus.mem_wdata, m_wdata);
                end
            end

            if (m_left == 1) begin
                if (m_write) ref_mem[m_addr[3:0]] = m_wdata;
                else if (m_owner) exp_d_rd = ref_mem[m_addr[3:0]];
                else exp_c_rd = ref_mem[m_addr[3:0]];
                if (m_owner) begin
                    n_cmp++; if (bus.dma_rdata !== exp_d_rd) begin
                        n_fail++;
                        $display("FAIL rnd_dma_rdata t%0d: got %h expected %h", cyc, bus.dma_rdata, exp_d_rd);
                    end
                    bus.dma_req = 1'b0; d_pend = 1'b0; d_gap = $urandom_range(0, 3);
                end else begin
                    n_cmp++; if (bus.cpu_rdata !== exp_c_rd) begin
                        n_fail++;
                        $display("FAIL rnd_cpu_rdata t%0d: got %h expected %h", cyc, bus.cpu_rdata, exp_c_rd);
                    end
                    bus.cpu_req = 1'b0; c_pend = 1'b0; c_gap = $urandom_range(0, 3);
                end
            end else begin
                if (!c_pend) begin
                    if (c_gap > 0) c_gap--;
                    else if ($urandom_range(0, 2) != 0) begin
                        c_pend = 1'b1; bus.cpu_req = 1'b1; bus.cpu_write = 1'($urandom_range(0, 1));
                        bus.cpu_address = 16'($urandom); bus.cpu_wdata = 8'($urandom);
                    end
                end
                if (!d_pend) begin
                    if (d_gap > 0) d_gap--;
                    else if ($urandom_range(0, 2) != 0) begin
                        d_pend = 1'b1; bus.dma_req = 1'b1; bus.dma_write = 1'($urandom_range(0, 1));
                        bus.dma_address = 16'($urandom); bus.dma_wdata = 8'($urandom);
                    end
                end
            end

            if (m_left > 0) begin
                m_left--;
            end else begin
                win_dma = bus.dma_req && (!bus.cpu_req || streak < MAXB);
                if (bus.cpu_req || bus.dma_req) begin
                    m_left  = W + 2;
                    m_owner = win_dma;
                    m_write = win_dma ? bus.dma_write   : bus.cpu_write;
                    m_addr  = win_dma ? bus.dma_address : bus.cpu_address;
                    m_wdata = win_dma ? bus.dma_wdata   : bus.cpu_wdata;
                end
                if (!bus.cpu_req || !win_dma) streak = 0;
                else if (streak < MAXB) streak++;
            end
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = 16'd0; bus.cpu_wdata = 8'd0;
        bus.dma_req = 1'b0; bus.dma_write = 1'b0; bus.dma_address = 16'd0; bus.dma_wdata = 8'd0;
        bus0.cpu_req = 1'b0; bus0.cpu_write = 1'b0; bus0.cpu_address = 16'd0; bus0.cpu_wdata = 8'd0;
        bus0.dma_req = 1'b0; bus0.dma_write = 1'b0; bus0.dma_address = 16'd0; bus0.dma_wdata = 8'd0;
        bus0.mem_rdata = 8'h5A;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_burst();
        test_back_to_back();
        test_reset_mid_write();
        test_drop_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
